// File: rtl/clock_period_meter.sv
// clock_period_meter
//   Measures the period of a slow asynchronous clock-like input in system
//   clock cycles. sig_in is synchronised, its rising edges are detected and the
//   number of clk cycles between two consecutive rising edges is presented on a
//   valid/ready interface.
//
//   Results that are overwritten before the consumer accepts them set the
//   sticky overrun flag. The timeout flag reports a dead input: no rising edge
//   within MAX_PERIOD cycles.
//
//   Optional feature macro: PERIOD_METER_DUTY_EN
//     When defined, a high_count port reports how many clk cycles the
//     synchronised input was high during the period just captured.
//     When undefined, the port and its counter are absent and everything else
//     behaves the same.
module clock_period_meter #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PERIOD  = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  input  logic                 period_ready,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 timeout
`ifdef PERIOD_METER_DUTY_EN
  ,
  output logic [CNT_WIDTH-1:0] high_count
`endif
);

  // Last value cnt_r may hold; reaching it without an edge means a dead input.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic [CNT_WIDTH-1:0]   cnt_r;

  logic                   sync_s;
  logic                   rise_s;
  logic                   capture_s;
  logic                   cnt_last_s;
  logic                   overrun_set_s;

`ifdef PERIOD_METER_DUTY_EN
  logic [CNT_WIDTH-1:0]   hcnt_r;
`endif

  // Synchroniser chain for the asynchronous input plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Edge strobe, capture qualifier and overrun condition.
  always_comb begin
    sync_s        = sync_r[SYNC_STAGES-1];
    rise_s        = sync_s & ~prev_r;
    capture_s     = (state_r == MEASURE) && rise_s;
    cnt_last_s    = (cnt_r == CNT_LAST);
    overrun_set_s = capture_s && period_valid && !period_ready;
  end

  // Measurement FSM: the first edge only arms the counter, later edges restart it,
  // and running out of count drops back to IDLE with timeout raised.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      timeout <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_r <= MEASURE;
            cnt_r   <= CNT_ZERO;
            timeout <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        MEASURE: begin
          if (rise_s) begin
            cnt_r <= CNT_ZERO;
          end else if (cnt_last_s) begin
            timeout <= 1'b1;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Result register and valid flag; a capture always wins over an acceptance
  // so a result arriving on the accept cycle is kept rather than dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period       <= CNT_ZERO;
      period_valid <= 1'b0;
    end else if (capture_s) begin
      // cnt_r counts from zero on the edge cycle, so the edge itself adds one.
      period       <= cnt_r + CNT_ONE;
      period_valid <= 1'b1;
    end else if (period_valid && period_ready) begin
      period_valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a new overwrite beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (overrun_set_s) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

`ifdef PERIOD_METER_DUTY_EN
  // High-time counter: restarts on each rising edge, counts while the synchronised
  // input is high and therefore holds still after the falling edge; saturates so a
  // stuck-high input cannot wrap it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_r <= CNT_ZERO;
    end else if (rise_s) begin
      hcnt_r <= CNT_ZERO;
    end else if (sync_s && (hcnt_r != CNT_LAST)) begin
      hcnt_r <= hcnt_r + CNT_ONE;
    end
  end

  // High-time result, loaded together with period so both describe the same period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      high_count <= CNT_ZERO;
    end else if (capture_s) begin
      // The edge cycle is itself a high cycle, hence the extra one.
      high_count <= hcnt_r + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter.
// The reference model keeps a history of the synchronised input and derives the
// expected results from rising-edge timestamps: period is the difference of
// consecutive edge times, high time is the number of high samples between them,
// and timeout fires when MAX_PERIOD cycles pass after an edge with no new one.
module tb_clock_period_meter;

  localparam int CW    = 16;
  localparam int SS    = 2;
  localparam int MP    = 64;
  localparam int HSIZE = 40000;

  logic          clk = 1'b0;
  logic          rst;
  logic          sig_in;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          period_ready;
  logic          overrun;
  logic          overrun_clr;
  logic          timeout;
`ifdef PERIOD_METER_DUTY_EN
  logic [CW-1:0] high_count;
`endif

  clock_period_meter #(
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(SS),
    .MAX_PERIOD (MP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .period      (period),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .timeout     (timeout)
`ifdef PERIOD_METER_DUTY_EN
    ,
    .high_count  (high_count)
`endif
  );

  // System clock, period 10.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Synchronised-input samples, one per clk edge; reset edges store 0.
  bit s_hist [0:HSIZE-1];
  int edge_n;

  // Reference-model state.
  bit m_meas;
  bit m_tmo;
  bit m_valid;
  bit m_ovr;
  int m_last;
  int m_period;
  int m_high;

  // Stimulus controls: 0 = fixed ready, 1 = random ready/clr, 2 = ready only on capture cycles.
  int ready_mode;
  bit ready_val;
  bit clr_pulse;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at time %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_meas   = 1'b0;
    m_tmo    = 1'b0;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_last   = 0;
    m_period = 0;
    m_high   = 0;
  endtask

  // One clk edge of the reference model; the synchroniser delays the input by two
  // edges, so a rise is seen at edge n when sample n-2 is high and n-3 low.
  task automatic model_edge(input bit s, input bit rdy, input bit clr);
    bit rise;
    bit cap;
    bit ovr_set;
    int hc;
    edge_n++;
    if (edge_n >= HSIZE) begin
      $display("FAIL history: edge index %0d beyond bound %0d", edge_n, HSIZE);
      $fatal(1, "history overflow");
    end
    s_hist[edge_n] = s;
    rise    = s_hist[edge_n-2] && !s_hist[edge_n-3];
    cap     = m_meas && rise;
    ovr_set = cap && m_valid && !rdy;
    if (cap) begin
      hc = 0;
      for (int m = m_last; m < edge_n; m++) begin
        if (s_hist[m-2]) hc++;
      end
      m_period = edge_n - m_last;
      m_high   = hc;
      m_last   = edge_n;
      m_valid  = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (ovr_set) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    if (!m_meas && rise) begin
      m_meas = 1'b1;
      m_last = edge_n;
      m_tmo  = 1'b0;
    end else if (m_meas && !rise && (edge_n - m_last == MP)) begin
      m_tmo  = 1'b1;
      m_meas = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    check("valid", {31'd0, period_valid}, {31'd0, m_valid});
    check("timeout", {31'd0, timeout}, {31'd0, m_tmo});
    check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    check("period", {16'd0, period}, m_period);
`ifdef PERIOD_METER_DUTY_EN
    check("high_count", {16'd0, high_count}, m_high);
`endif
  endtask

  // One clk cycle: choose handshake inputs, let the edge happen, then check #1 later.
  task automatic step();
    bit rdy;
    bit clr;
    case (ready_mode)
      0:       rdy = ready_val;
      1:       rdy = 1'($urandom_range(0, 1));
      2:       rdy = m_meas && s_hist[edge_n-1] && !s_hist[edge_n-2];
      default: rdy = 1'b1;
    endcase
    clr = clr_pulse || ((ready_mode == 1) && ($urandom_range(0, 15) == 0));
    clr_pulse    = 1'b0;
    period_ready = rdy;
    overrun_clr  = clr;
    @(posedge clk);
    model_edge(sig_in, rdy, clr);
    #1;
    compare_outputs();
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) begin
        sig_in = 1'b1;
        step();
      end
      for (int i = 0; i < lo; i++) begin
        sig_in = 1'b0;
        step();
      end
    end
  endtask

  task automatic level(input bit v, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      sig_in = v;
      step();
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input int cycles);
    rst = 1'b0;
    #1;
    check("rst_valid", {31'd0, period_valid}, 32'd0);
    check("rst_period", {16'd0, period}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
`ifdef PERIOD_METER_DUTY_EN
    check("rst_high_count", {16'd0, high_count}, 32'd0);
`endif
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      edge_n++;
      s_hist[edge_n] = 1'b0;
    end
    model_clear();
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    sig_in       = 1'b0;
    period_ready = 1'b1;
    overrun_clr  = 1'b0;
    ready_mode   = 0;
    ready_val    = 1'b1;
    clr_pulse    = 1'b0;
    edge_n       = 8;
    model_clear();
    #3;
    do_reset(4);

    // 8 high / 8 low, always ready.
    wave(8, 8, 6);

    // Consumer stalls across several captures, then overrun is cleared and ready returns.
    ready_val = 1'b0;
    wave(8, 8, 4);
    clr_pulse = 1'b1;
    level(1'b1, 1);
    level(1'b1, 2);
    ready_val = 1'b1;
    wave(8, 8, 3);

    // Input dies low: timeout, then an IDLE edge, then a real result.
    level(1'b0, 100);
    wave(8, 8, 4);

    // Reset in the middle of a high phase.
    wave(8, 8, 3);
    level(1'b1, 4);
    do_reset(5);
    wave(8, 8, 4);

    // Unequal duty cycle.
    wave(5, 11, 5);

    // Ready asserted only on capture cycles of a 10-cycle input.
    clr_pulse  = 1'b1;
    ready_mode = 2;
    wave(5, 5, 6);

    // Stuck-high input reaches timeout as well.
    level(1'b1, 80);
    wave(6, 6, 3);

    // Random segments with random handshake, occasional long gaps and resets.
    ready_mode = 1;
    for (int k = 0; k < 150; k++) begin
      int hi;
      int lo;
      hi = $urandom_range(1, 30);
      lo = $urandom_range(1, 30);
      if ($urandom_range(0, 9) == 0) lo = $urandom_range(60, 90);
      wave(hi, lo, 1);
      if ((k % 50) == 25) do_reset(4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
